// File: rtl/alu_sched.sv
// alu_sched: round-robin scheduler in front of one shared combinational ALU.
//
// One request is accepted at a time over a per-requester valid/ready
// handshake. Its operands and opcode are registered towards the ALU. The ALU
// result is captured and returned with the requester index over a
// valid/ready response channel.
//
// Ports:
//   clk, rst            clock (rising edge), synchronous active-high reset
//   req_valid/req_ready per-requester handshake; req_ready is one-hot or zero
//   req_a/req_b/req_op  packed per-requester operands and opcode
//   alu_a/alu_b/alu_opcode  registered operands to the ALU
//   alu_result/alu_ready    ALU result and its valid indication
//   resp_valid/resp_ready   response handshake
//   resp_data/resp_id/resp_err  captured result, served requester, div-by-zero
//
// Optional feature: define ALU_SCHED_DIVZERO_CHK_EN to answer a divide by
// zero directly with resp_data = 0 and resp_err = 1, without using the ALU.
module alu_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*2-1:0]      req_op,
    output logic [DATA_W-1:0]         alu_a,
    output logic [DATA_W-1:0]         alu_b,
    output logic [1:0]                alu_opcode,
    input  logic [DATA_W-1:0]         alu_result,
    input  logic                      alu_ready,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_W-1:0]         resp_data,
    output logic [ID_W-1:0]           resp_id,
    output logic                      resp_err
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   cur_id;
    logic [ID_W-1:0]   grant;
    logic              found;
    logic              divz;
    int unsigned       idx;

    logic [DATA_W-1:0] a_arr  [NUM_REQ];
    logic [DATA_W-1:0] b_arr  [NUM_REQ];
    logic [1:0]        op_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i]  = req_b[i*DATA_W +: DATA_W];
        assign op_arr[i] = req_op[i*2 +: 2];
    end

    // Round-robin pick: first valid requester at or after last_grant+1, wrapping.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(last_grant) + k) % NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && j == idx && req_valid[j]) begin
                    found = 1'b1;
                    grant = ID_W'(j);
                end
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found)
            req_ready[grant] = 1'b1;
    end

`ifdef ALU_SCHED_DIVZERO_CHK_EN
    assign divz = (op_arr[grant] == 2'b11) && (b_arr[grant] == '0);
`else
    // Without the check resp_err is never set and stays at its reset value 0.
    assign divz = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            cur_id     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        cur_id     <= grant;
                        last_grant <= grant;
                        if (divz) begin
                            // ALU bypassed: operands keep their previous values.
                            resp_data  <= '0;
                            resp_id    <= grant;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end else begin
                            alu_a      <= a_arr[grant];
                            alu_b      <= b_arr[grant];
                            alu_opcode <= op_arr[grant];
                            state      <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    if (alu_ready) begin
                        resp_data  <= alu_result;
                        resp_id    <= cur_id;
                        resp_err   <= 1'b0;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_sched.md
# alu_sched

Round-robin scheduler sharing one combinational 32-bit ALU (2-bit opcode: 00 add, 01 sub, 10 mul, 11 div) among `NUM_REQ` requesters. It accepts one request at a time with a valid/ready handshake and registers the operands into the ALU. It captures the ALU result and returns it with the requester ID over a valid/ready response channel. It sits between the client blocks and the single ALU instance.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 32: operand/result width; must match the ALU.
- `ID_W`, 2: width of the requester ID; equals clog2(`NUM_REQ`).

- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in `NUM_REQ`: per-requester request valid.
- `req_ready` out `NUM_REQ`: per-requester accept strobe, at most one bit high.
- `req_a` in `NUM_REQ*DATA_W`: operand a, requester i at bits [i*DATA_W +: DATA_W].
- `req_b` in `NUM_REQ*DATA_W`: operand b, same packing.
- `req_op` in `NUM_REQ*2`: opcode, requester i at [i*2 +: 2].
- `alu_a`, `alu_b` out `DATA_W`: registered operands to the ALU.
- `alu_opcode` out 2: registered opcode to the ALU.
- `alu_result` in `DATA_W`: ALU result.
- `alu_ready` in 1: ALU result-valid indication.
- `resp_valid` out 1: response valid.
- `resp_ready` in 1: response consumer ready.
- `resp_data` out `DATA_W`: captured result.
- `resp_id` out `ID_W`: index of the served requester.
- `resp_err` out 1: divide-by-zero flag; only active with `ALU_SCHED_DIVZERO_CHK_EN`.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE**
  - If any `req_valid` is high, grant the first requester with `req_valid` high, searching upward (with wrap) from `last_grant+1`.
  - `req_ready[grant]` is high combinationally in this cycle only.
  - On the edge: latch a, b, op into `alu_a`/`alu_b`/`alu_opcode`, latch grant into `cur_id`, update `last_grant` to grant, and go to EXEC.
  - With no valid request, stay in IDLE; `req_ready` = 0.
- **EXEC**
  - Operands are held stable.
  - If `alu_ready` is high on the edge, capture `alu_result` into `resp_data` and `cur_id` into `resp_id`, then go to RESP.
  - Otherwise stay in EXEC indefinitely.
- **RESP**
  - `resp_valid` = 1.
  - `resp_data`, `resp_id` and `resp_err` are held stable until the edge where `resp_ready` is high, then go to IDLE.
- `req_ready` is 0 in EXEC and RESP; requests are never dropped, only held off.
- The scheduler has no knowledge of opcode semantics except the divide-by-zero check.
- Arithmetic is done by the ALU only; result width is `DATA_W` with no truncation by the scheduler.

## Timing
- Reset values:
  - state IDLE; `last_grant` = `NUM_REQ-1`, so requester 0 has first priority.
  - `req_ready` = 0, `alu_a` = 0, `alu_b` = 0, `alu_opcode` = 0.
  - `resp_valid` = 0, `resp_data` = 0, `resp_id` = 0, `resp_err` = 0.
- Latency: request accepted at edge T. With `alu_ready` = 1, `resp_valid` is high from edge T+2. Minimum issue interval is 3 cycles when `resp_ready` stays high.
- Response backpressure: `resp_valid` held high for any number of cycles; outputs stable.
- Reset mid-operation (EXEC or RESP): the in-flight operation is discarded and all outputs take their reset values at the next edge.
- `req_valid` deasserted by a requester while not granted: no effect.
- Fairness: a requester held valid continuously is served within `NUM_REQ` grants.

## Configuration
- `ALU_SCHED_DIVZERO_CHK_EN` defined:
  - In IDLE, an accepted request with op = 11 and b = 0 does not use the ALU. The FSM goes directly to RESP at the next edge with `resp_data` = 0 and `resp_err` = 1.
  - `alu_a`/`alu_b`/`alu_opcode` keep their previous values.
  - All other requests give `resp_err` = 0.
- Not defined: all requests go through EXEC; `resp_err` is tied to 0; the divide-by-zero result is whatever the ALU returns.

## Test plan
- Single request: req 1, a = 7, b = 5, op = 00 -> `req_ready` = 0010 for one cycle; `resp_valid` at T+2 with `resp_data` = 12, `resp_id` = 1.
- Round-robin: all four valid continuously, each with a distinct op (for example req 2 with 100, 7, op 01 -> 93), `resp_ready` = 1 -> grant order 0,1,2,3,0 and correct results per ID.
- Backpressure: `resp_ready` = 0 for 5 cycles after `resp_valid` -> data/ID stable; no `req_ready` during the hold; next grant one cycle after the handshake.
- ALU stall: `alu_ready` = 0 for 3 cycles in EXEC with a = 6, b = 7, op = 10 -> operands stable; `resp_data` = 42 one edge after `alu_ready` rises.
- Divide-by-zero with the macro: a = 9, b = 0, op = 11 -> `resp_valid` at T+1, `resp_data` = 0, `resp_err` = 1. Without the macro: `resp_err` = 0, EXEC path taken.
- Reset in RESP with `resp_valid` = 1 -> all outputs 0 next cycle; next grant goes to requester 0 when all requesters are valid.
